// File: rtl/proc_io_port.sv
// proc_io_port: processor I/O port with a show-ahead input FIFO (external -> core)
// and an output FIFO (core -> external), each DEPTH words of DATA_W bits.
// Input words arriving while the input FIFO is full are dropped and flagged on ovf.
// Optional feature: define PROC_IO_OVF_CNT_EN to add a saturating 8-bit drop counter
// on ovf_cnt; without it ovf_cnt is tied to zero.
module proc_io_port #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              system1000,
   input  logic              system1000_rstn,
   input  logic              iEn,
   input  logic [DATA_W-1:0] PIn,
   output logic              iFull,
   output logic              core_in_vld,
   output logic [DATA_W-1:0] core_in_data,
   input  logic              core_rd,
   input  logic              core_wr,
   input  logic [DATA_W-1:0] core_out_data,
   output logic              core_out_rdy,
   output logic              oEn,
   output logic [DATA_W-1:0] POut,
   input  logic              oRdy,
   output logic              ovf,
   input  logic              ovf_clr,
   output logic [7:0]        ovf_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   // Pointers carry one extra wrap bit so full and empty are distinct without a spare slot.
   logic [AW:0]       in_wr_ptr_reg, in_rd_ptr_reg;
   logic [AW:0]       out_wr_ptr_reg, out_rd_ptr_reg;
   logic [DATA_W-1:0] in_mem  [DEPTH];
   logic [DATA_W-1:0] out_mem [DEPTH];
   logic              ovf_reg;

   logic in_empty, in_full, in_push, in_pop, in_drop;
   logic out_empty, out_full, out_push, out_pop;

   // Status decode and handshake qualification for both FIFOs.
   always_comb begin
      in_empty  = (in_wr_ptr_reg == in_rd_ptr_reg);
      in_full   = (in_wr_ptr_reg[AW] != in_rd_ptr_reg[AW]) &&
                  (in_wr_ptr_reg[AW-1:0] == in_rd_ptr_reg[AW-1:0]);
      out_empty = (out_wr_ptr_reg == out_rd_ptr_reg);
      out_full  = (out_wr_ptr_reg[AW] != out_rd_ptr_reg[AW]) &&
                  (out_wr_ptr_reg[AW-1:0] == out_rd_ptr_reg[AW-1:0]);
      // A full input FIFO still accepts a word when the core frees a slot in the same cycle.
      in_pop    = core_rd && !in_empty;
      in_push   = iEn && (!in_full || core_rd);
      in_drop   = iEn && in_full && !core_rd;
      // Output push looks only at pre-edge fullness; a same-cycle pop does not make room.
      out_pop   = !out_empty && oRdy;
      out_push  = core_wr && !out_full;
   end

   // Input FIFO pointers; reset discards all stored words.
   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         in_wr_ptr_reg <= '0;
         in_rd_ptr_reg <= '0;
      end else begin
         if (in_push) in_wr_ptr_reg <= in_wr_ptr_reg + PTR_ONE;
         if (in_pop)  in_rd_ptr_reg <= in_rd_ptr_reg + PTR_ONE;
      end
   end

   // Output FIFO pointers.
   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         out_wr_ptr_reg <= '0;
         out_rd_ptr_reg <= '0;
      end else begin
         if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + PTR_ONE;
         if (out_pop)  out_rd_ptr_reg <= out_rd_ptr_reg + PTR_ONE;
      end
   end

   // Storage arrays: write-only clocked, contents survive reset by design.
   always_ff @(posedge system1000) begin
      if (in_push)  in_mem[in_wr_ptr_reg[AW-1:0]]   <= PIn;
      if (out_push) out_mem[out_wr_ptr_reg[AW-1:0]] <= core_out_data;
   end

   // Sticky overflow flag; a drop in the clearing cycle keeps it set.
   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn)  ovf_reg <= 1'b0;
      else if (in_drop)      ovf_reg <= 1'b1;
      else if (ovf_clr)      ovf_reg <= 1'b0;
   end

`ifdef PROC_IO_OVF_CNT_EN
   logic [7:0] ovf_cnt_reg;

   // Saturating dropped-word counter; clearing alongside a drop restarts at one.
   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn)
         ovf_cnt_reg <= 8'd0;
      else if (ovf_clr)
         ovf_cnt_reg <= in_drop ? 8'd1 : 8'd0;
      else if (in_drop && (ovf_cnt_reg != 8'hFF))
         ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
   end

   assign ovf_cnt = ovf_cnt_reg;
`else
   assign ovf_cnt = 8'd0;
`endif

   // Show-ahead heads, forced to zero whenever the corresponding FIFO is empty.
   always_comb begin
      iFull        = in_full;
      core_in_vld  = !in_empty;
      core_in_data = in_empty ? '0 : in_mem[in_rd_ptr_reg[AW-1:0]];
      core_out_rdy = !out_full;
      oEn          = !out_empty;
      POut         = out_empty ? '0 : out_mem[out_rd_ptr_reg[AW-1:0]];
      ovf          = ovf_reg;
   end

endmodule

// File: tb/tb_proc_io_port.sv
// tb_proc_io_port: directed-vector bench for proc_io_port (DATA_W=16, DEPTH=4).
// Expected drop-counter values follow PROC_IO_OVF_CNT_EN when it is defined.
module tb_proc_io_port;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;

`ifdef PROC_IO_OVF_CNT_EN
   localparam logic [7:0] CNT_ONE = 8'd1;
   localparam logic [7:0] CNT_SAT = 8'd255;
`else
   localparam logic [7:0] CNT_ONE = 8'd0;
   localparam logic [7:0] CNT_SAT = 8'd0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              iEn = 1'b0;
   logic [DATA_W-1:0] PIn = '0;
   logic              iFull;
   logic              core_in_vld;
   logic [DATA_W-1:0] core_in_data;
   logic              core_rd = 1'b0;
   logic              core_wr = 1'b0;
   logic [DATA_W-1:0] core_out_data = '0;
   logic              core_out_rdy;
   logic              oEn;
   logic [DATA_W-1:0] POut;
   logic              oRdy = 1'b0;
   logic              ovf;
   logic              ovf_clr = 1'b0;
   logic [7:0]        ovf_cnt;

   int n_vec = 0;
   int n_err = 0;

   proc_io_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .system1000      (clk),
      .system1000_rstn (rst_n),
      .iEn             (iEn),
      .PIn             (PIn),
      .iFull           (iFull),
      .core_in_vld     (core_in_vld),
      .core_in_data    (core_in_data),
      .core_rd         (core_rd),
      .core_wr         (core_wr),
      .core_out_data   (core_out_data),
      .core_out_rdy    (core_out_rdy),
      .oEn             (oEn),
      .POut            (POut),
      .oRdy            (oRdy),
      .ovf             (ovf),
      .ovf_clr         (ovf_clr),
      .ovf_cnt         (ovf_cnt)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      if (iFull !== 1'b0)        begin $display("FAIL rst_iFull: got %0h exp 0", iFull); n_err++; end n_vec++;
      if (core_in_vld !== 1'b0)  begin $display("FAIL rst_in_vld: got %0h exp 0", core_in_vld); n_err++; end n_vec++;
      if (core_in_data !== 16'h0) begin $display("FAIL rst_in_data: got %0h exp 0", core_in_data); n_err++; end n_vec++;
      if (core_out_rdy !== 1'b1) begin $display("FAIL rst_out_rdy: got %0h exp 1", core_out_rdy); n_err++; end n_vec++;
      if (oEn !== 1'b0)          begin $display("FAIL rst_oEn: got %0h exp 0", oEn); n_err++; end n_vec++;
      if (POut !== 16'h0)        begin $display("FAIL rst_POut: got %0h exp 0", POut); n_err++; end n_vec++;
      if (ovf !== 1'b0)          begin $display("FAIL rst_ovf: got %0h exp 0", ovf); n_err++; end n_vec++;
      if (ovf_cnt !== 8'd0)      begin $display("FAIL rst_ovf_cnt: got %0d exp 0", ovf_cnt); n_err++; end n_vec++;
      tick();
      tick();
      rst_n = 1'b1;
      $display("reset: released, %0d miscompares so far", n_err);
   endtask

   task automatic test_single_word();
      iEn = 1'b1; PIn = 16'hFFFB;   // -5
      tick();
      iEn = 1'b0;
      if (core_in_vld !== 1'b1)     begin $display("FAIL single_vld: got %0h exp 1", core_in_vld); n_err++; end n_vec++;
      if (core_in_data !== 16'hFFFB) begin $display("FAIL single_data: got %0h exp fffb", core_in_data); n_err++; end n_vec++;
      core_rd = 1'b1;
      tick();
      core_rd = 1'b0;
      if (core_in_vld !== 1'b0)     begin $display("FAIL single_pop_vld: got %0h exp 0", core_in_vld); n_err++; end n_vec++;
      if (core_in_data !== 16'h0)   begin $display("FAIL single_pop_data: got %0h exp 0", core_in_data); n_err++; end n_vec++;
      // A pop on an empty FIFO must not disturb the pointers.
      core_rd = 1'b1;
      tick();
      core_rd = 1'b0;
      iEn = 1'b1; PIn = 16'h1234;
      tick();
      iEn = 1'b0;
      if (core_in_data !== 16'h1234) begin $display("FAIL empty_pop_data: got %0h exp 1234", core_in_data); n_err++; end n_vec++;
      core_rd = 1'b1;
      tick();
      core_rd = 1'b0;
      if (core_in_vld !== 1'b0)     begin $display("FAIL empty_pop_vld: got %0h exp 0", core_in_vld); n_err++; end n_vec++;
      $display("single_word: -5 round trip done, %0d miscompares so far", n_err);
   endtask

   task automatic test_overflow();
      for (int k = 0; k < 5; k++) begin
         iEn = 1'b1; PIn = 16'(10 + k);
         tick();
         if (k == 2 && iFull !== 1'b0) begin $display("FAIL ovf_notfull3: got %0h exp 0", iFull); n_err++; end
         if (k == 2) n_vec++;
         if (k == 3 && iFull !== 1'b1) begin $display("FAIL ovf_full4: got %0h exp 1", iFull); n_err++; end
         if (k == 3) n_vec++;
         if (k == 3 && ovf !== 1'b0)   begin $display("FAIL ovf_early: got %0h exp 0", ovf); n_err++; end
         if (k == 3) n_vec++;
      end
      iEn = 1'b0;
      if (ovf !== 1'b1)             begin $display("FAIL ovf_set: got %0h exp 1", ovf); n_err++; end n_vec++;
      if (ovf_cnt !== CNT_ONE)      begin $display("FAIL ovf_cnt1: got %0d exp %0d", ovf_cnt, CNT_ONE); n_err++; end n_vec++;
      if (core_in_data !== 16'd10)  begin $display("FAIL ovf_head: got %0h exp a", core_in_data); n_err++; end n_vec++;
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      if (ovf !== 1'b0)             begin $display("FAIL ovf_clr: got %0h exp 0", ovf); n_err++; end n_vec++;
      if (ovf_cnt !== 8'd0)         begin $display("FAIL ovf_cnt_clr: got %0d exp 0", ovf_cnt); n_err++; end n_vec++;
      $display("overflow: 5 strobes into depth 4, %0d miscompares so far", n_err);
   endtask

   task automatic test_full_push_pop();
      logic [DATA_W-1:0] exp_q [4];
      exp_q[0] = 16'd11; exp_q[1] = 16'd12; exp_q[2] = 16'd13; exp_q[3] = 16'd20;
      iEn = 1'b1; core_rd = 1'b1; PIn = 16'd20;
      tick();
      iEn = 1'b0; core_rd = 1'b0;
      if (iFull !== 1'b1)           begin $display("FAIL fullrw_full: got %0h exp 1", iFull); n_err++; end n_vec++;
      if (ovf !== 1'b0)             begin $display("FAIL fullrw_ovf: got %0h exp 0", ovf); n_err++; end n_vec++;
      for (int k = 0; k < 4; k++) begin
         if (core_in_data !== exp_q[k]) begin
            $display("FAIL fullrw_order%0d: got %0h exp %0h", k, core_in_data, exp_q[k]); n_err++;
         end
         n_vec++;
         core_rd = 1'b1;
         tick();
         core_rd = 1'b0;
      end
      if (core_in_vld !== 1'b0)     begin $display("FAIL fullrw_empty: got %0h exp 0", core_in_vld); n_err++; end n_vec++;
      $display("full_push_pop: simultaneous push/pop on full FIFO, %0d miscompares so far", n_err);
   endtask

   task automatic test_output();
      for (int k = 1; k <= 4; k++) begin
         core_wr = 1'b1; core_out_data = 16'(k);
         tick();
      end
      core_wr = 1'b0;
      if (core_out_rdy !== 1'b0)    begin $display("FAIL out_rdy_full: got %0h exp 0", core_out_rdy); n_err++; end n_vec++;
      if (oEn !== 1'b1)             begin $display("FAIL out_oEn: got %0h exp 1", oEn); n_err++; end n_vec++;
      core_wr = 1'b1; core_out_data = 16'd5;
      tick();
      core_out_data = 16'd6;
      tick();
      core_wr = 1'b0;
      oRdy = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         if (POut !== 16'(k)) begin $display("FAIL out_order%0d: got %0h exp %0h", k, POut, k); n_err++; end
         n_vec++;
         tick();
      end
      oRdy = 1'b0;
      if (oEn !== 1'b0)             begin $display("FAIL out_drained_oEn: got %0h exp 0", oEn); n_err++; end n_vec++;
      if (POut !== 16'h0)           begin $display("FAIL out_drained_POut: got %0h exp 0", POut); n_err++; end n_vec++;
      if (core_out_rdy !== 1'b1)    begin $display("FAIL out_rdy_empty: got %0h exp 1", core_out_rdy); n_err++; end n_vec++;
      // Push into a full FIFO during a pop is rejected.
      for (int k = 7; k <= 10; k++) begin
         core_wr = 1'b1; core_out_data = 16'(k);
         tick();
      end
      core_out_data = 16'd99; oRdy = 1'b1;
      tick();
      core_wr = 1'b0;
      for (int k = 8; k <= 10; k++) begin
         if (POut !== 16'(k)) begin $display("FAIL out_fullpop%0d: got %0h exp %0h", k, POut, k); n_err++; end
         n_vec++;
         tick();
      end
      oRdy = 1'b0;
      if (oEn !== 1'b0)             begin $display("FAIL out_fullpop_oEn: got %0h exp 0", oEn); n_err++; end n_vec++;
      $display("output: ordered drain and full-FIFO rejection, %0d miscompares so far", n_err);
   endtask

   task automatic test_saturation();
      iEn = 1'b1; PIn = 16'h00AA;
      for (int k = 0; k < 304; k++) tick();
      if (ovf_cnt !== CNT_SAT)      begin $display("FAIL sat_cnt: got %0d exp %0d", ovf_cnt, CNT_SAT); n_err++; end n_vec++;
      if (ovf !== 1'b1)             begin $display("FAIL sat_ovf: got %0h exp 1", ovf); n_err++; end n_vec++;
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0; iEn = 1'b0;
      if (ovf !== 1'b1)             begin $display("FAIL clr_drop_ovf: got %0h exp 1", ovf); n_err++; end n_vec++;
      if (ovf_cnt !== CNT_ONE)      begin $display("FAIL clr_drop_cnt: got %0d exp %0d", ovf_cnt, CNT_ONE); n_err++; end n_vec++;
      $display("saturation: 300 drops then clear with drop, %0d miscompares so far", n_err);
   endtask

   task automatic test_async_reset();
      // Leave the input FIFO half full (ovf still set) and the output FIFO half full.
      core_rd = 1'b1;
      tick();
      tick();
      core_rd = 1'b0;
      core_wr = 1'b1; core_out_data = 16'd55;
      tick();
      core_out_data = 16'd56;
      tick();
      core_wr = 1'b0;
      if (core_in_vld !== 1'b1 || oEn !== 1'b1 || ovf !== 1'b1) begin
         $display("FAIL arst_pre: got vld=%0h oEn=%0h ovf=%0h exp 1 1 1", core_in_vld, oEn, ovf); n_err++;
      end
      n_vec++;
      #3 rst_n = 1'b0;
      #1;
      if (iFull !== 1'b0)        begin $display("FAIL arst_iFull: got %0h exp 0", iFull); n_err++; end n_vec++;
      if (core_in_vld !== 1'b0)  begin $display("FAIL arst_in_vld: got %0h exp 0", core_in_vld); n_err++; end n_vec++;
      if (core_in_data !== 16'h0) begin $display("FAIL arst_in_data: got %0h exp 0", core_in_data); n_err++; end n_vec++;
      if (core_out_rdy !== 1'b1) begin $display("FAIL arst_out_rdy: got %0h exp 1", core_out_rdy); n_err++; end n_vec++;
      if (oEn !== 1'b0)          begin $display("FAIL arst_oEn: got %0h exp 0", oEn); n_err++; end n_vec++;
      if (POut !== 16'h0)        begin $display("FAIL arst_POut: got %0h exp 0", POut); n_err++; end n_vec++;
      if (ovf !== 1'b0)          begin $display("FAIL arst_ovf: got %0h exp 0", ovf); n_err++; end n_vec++;
      if (ovf_cnt !== 8'd0)      begin $display("FAIL arst_ovf_cnt: got %0d exp 0", ovf_cnt); n_err++; end n_vec++;
      #1 rst_n = 1'b1;
      iEn = 1'b1; PIn = 16'd77;
      tick();
      iEn = 1'b0;
      if (core_in_data !== 16'd77) begin $display("FAIL arst_first_edge: got %0h exp 4d", core_in_data); n_err++; end n_vec++;
      if (oEn !== 1'b0)          begin $display("FAIL arst_out_discard: got %0h exp 0", oEn); n_err++; end n_vec++;
      $display("async_reset: mid-transfer reset and first-edge write, %0d miscompares so far", n_err);
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_overflow();
      test_full_push_pop();
      test_output();
      test_saturation();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
